gate_pattern_sequencer: RTL and testbench

//  Clocked stimulus source that sits directly upstream of data_flow_model.

---
 rtl/gate_pattern_if.sv | 44 ++++
 rtl/gate_pattern_sequencer.sv | 157 +++++++++++++++
 tb/tb_gate_pattern_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_pattern_if.sv
// Handshake and stimulus bundle between gate_pattern_sequencer and its consumer.
// GATE_CHECK_EN adds the gate feedback inputs and the error-count outputs.
interface gate_pattern_if;
  logic       start;
  logic       mode;
  logic       a;
  logic       b;
  logic       pattern_valid;
  logic [1:0] pattern_idx;
  logic       busy;
  logic       done;
`ifdef GATE_CHECK_EN
  logic       xor_g;
  logic       and_g;
  logic       not_g;
  logic       buffe_g;
  logic       or_g;
  logic       nand_g;
  logic [7:0] err_count;
  logic       err_flag;

  modport master (
    input  start, mode,
    input  xor_g, and_g, not_g, buffe_g, or_g, nand_g,
    output a, b, pattern_valid, pattern_idx, busy, done,
    output err_count, err_flag
  );
  modport slave (
    output start, mode,
    output xor_g, and_g, not_g, buffe_g, or_g, nand_g,
    input  a, b, pattern_valid, pattern_idx, busy, done,
    input  err_count, err_flag
  );
`else
  modport master (
    input  start, mode,
    output a, b, pattern_valid, pattern_idx, busy, done
  );
  modport slave (
    output start, mode,
    input  a, b, pattern_valid, pattern_idx, busy, done
  );
`endif
endinterface

// File: rtl/gate_pattern_sequencer.sv
// Sweeps {a,b} through all four patterns (binary or Gray), HOLD_CYCLES each.
// Define GATE_CHECK_EN to add the downstream gate self-check counter.
module gate_pattern_sequencer #(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_PASSES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  gate_pattern_if.master bus
);

  localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int PASS_EFF = (NUM_PASSES == 0) ? 1 : NUM_PASSES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(PASS_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_idx, w_idx;
  logic [CNT_W-1:0] r_hold, w_hold;
  logic [CNT_W-1:0] r_pass, w_pass;
  logic             r_mode, w_mode;
  logic             r_a, w_a;
  logic             r_b, w_b;
  logic             r_valid, w_valid;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_last_hold;
  logic [1:0]       w_pat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_pass  <= '0;
      r_mode  <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_hold  <= w_hold;
      r_pass  <= w_pass;
      r_mode  <= w_mode;
      r_a     <= w_a;
      r_b     <= w_b;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign w_last_hold = (r_hold == HOLD_LAST);

  // Outputs are computed one cycle early so they register alongside the state.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_hold  = r_hold;
    w_pass  = r_pass;
    w_mode  = r_mode;
    w_a     = 1'b0;
    w_b     = 1'b0;
    w_valid = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_pat   = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state = S_DRIVE;
          w_mode  = bus.mode;
          w_idx   = '0;
          w_hold  = '0;
          w_pass  = '0;
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end
      end
      S_DRIVE: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (w_last_hold) begin
          w_hold = '0;
          w_idx  = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (r_pass == PASS_LAST) begin
              w_state = S_DONE;
              w_valid = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_pass = r_pass + CNT_W'(1);
            end
          end
        end else begin
          w_hold = r_hold + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    if (w_valid) begin
      w_pat = w_mode ? (w_idx ^ {1'b0, w_idx[1]}) : w_idx;
      w_a   = w_pat[1];
      w_b   = w_pat[0];
    end
  end

  assign bus.a             = r_a;
  assign bus.b             = r_b;
  assign bus.pattern_valid = r_valid;
  assign bus.pattern_idx   = r_idx;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

`ifdef GATE_CHECK_EN
  logic [7:0] r_err;
  logic       w_sample;
  logic       w_gate_bad;

  assign w_sample   = (r_state == S_DRIVE) && w_last_hold;
  assign w_gate_bad = (bus.xor_g   != (r_a ^ r_b))
                    | (bus.and_g   != (r_a & r_b))
                    | (bus.not_g   != ~r_a)
                    | (bus.buffe_g != r_a)
                    | (bus.or_g    != (r_a | r_b))
                    | (bus.nand_g  != ~(r_a & r_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_err <= '0;
    end else if (w_sample && w_gate_bad && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign bus.err_count = r_err;
  assign bus.err_flag  = (r_err != 8'd0);
`endif

endmodule

// File: tb/tb_gate_pattern_sequencer.sv
// Directed bench for gate_pattern_sequencer: reset, binary, Gray, passes, hold=0.
// With GATE_CHECK_EN defined it also exercises the gate self-check.
module tb_gate_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  gate_pattern_if if0 ();
  gate_pattern_if if1 ();
  gate_pattern_if if2 ();

  gate_pattern_sequencer #(.HOLD_CYCLES(10), .NUM_PASSES(1), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  gate_pattern_sequencer #(.HOLD_CYCLES(1), .NUM_PASSES(3), .CNT_W(8))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  gate_pattern_sequencer #(.HOLD_CYCLES(0), .NUM_PASSES(1), .CNT_W(8))
    u2 (.clk(clk), .rst(rst), .bus(if2));

`ifdef GATE_CHECK_EN
  logic force_and = 1'b0;
  assign if0.xor_g   = if0.a ^ if0.b;
  assign if0.and_g   = force_and ? 1'b0 : (if0.a & if0.b);
  assign if0.not_g   = ~if0.a;
  assign if0.buffe_g = if0.a;
  assign if0.or_g    = if0.a | if0.b;
  assign if0.nand_g  = ~(if0.a & if0.b);
  assign if1.xor_g   = if1.a ^ if1.b;
  assign if1.and_g   = if1.a & if1.b;
  assign if1.not_g   = ~if1.a;
  assign if1.buffe_g = if1.a;
  assign if1.or_g    = if1.a | if1.b;
  assign if1.nand_g  = ~(if1.a & if1.b);
  assign if2.xor_g   = if2.a ^ if2.b;
  assign if2.and_g   = if2.a & if2.b;
  assign if2.not_g   = ~if2.a;
  assign if2.buffe_g = if2.a;
  assign if2.or_g    = if2.a | if2.b;
  assign if2.nand_g  = ~(if2.a & if2.b);
`endif

  // {a, b, pattern_valid, busy, done, pattern_idx}
  logic [6:0] obs0, obs1, obs2;
  assign obs0 = {if0.a, if0.b, if0.pattern_valid, if0.busy, if0.done, if0.pattern_idx};
  assign obs1 = {if1.a, if1.b, if1.pattern_valid, if1.busy, if1.done, if1.pattern_idx};
  assign obs2 = {if2.a, if2.b, if2.pattern_valid, if2.busy, if2.done, if2.pattern_idx};

  localparam logic [6:0] DONE_V = 7'b00_0_1_1_00;
  logic [1:0] BIN [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] GRY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    if0.start = 1'b0; if0.mode = 1'b0;
    if1.start = 1'b0; if1.mode = 1'b0;
    if2.start = 1'b0; if2.mode = 1'b0;
    repeat (2) @(negedge clk);
    if ({obs0, obs1, obs2} !== 21'd0) $display("FAIL reset_state got %b want 0", {obs0, obs1, obs2});
    else n_pass++;
    n_total++;
    rst = 1'b0;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (14) @(negedge clk);
    if (obs0 !== 7'b01_110_01) $display("FAIL reset_pre got %b want 0111001", obs0);
    else n_pass++;
    n_total++;
    rst = 1'b1;
    #1;
    if (obs0 !== 7'd0) $display("FAIL reset_async got %b want 0", obs0);
    else n_pass++;
    n_total++;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      dones += int'(if0.done);
    end
    if (dones != 0) $display("FAIL reset_no_done got %0d want 0", dones);
    else n_pass++;
    n_total++;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if (obs0 !== 7'b00_110_00) $display("FAIL reset_restart got %b want 0011000", obs0);
    else n_pass++;
    n_total++;
    repeat (41) @(negedge clk);
    if (obs0 !== 7'd0) $display("FAIL reset_end_idle got %b want 0", obs0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_binary();
    logic [6:0] exp;
    int busy_n = 0;
    int done_n = 0;
    if0.mode = 1'b0;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    for (int k = 0; k < 42; k++) begin
      if (k < 40) exp = {BIN[k/10], 3'b110, 2'(k/10)};
      else if (k == 40) exp = DONE_V;
      else exp = 7'd0;
      if (obs0 !== exp) $display("FAIL binary k=%0d got %b want %b", k, obs0, exp);
      else n_pass++;
      n_total++;
      busy_n += int'(if0.busy);
      done_n += int'(if0.done);
      @(negedge clk);
    end
    if (busy_n != 41) $display("FAIL binary_busy got %0d want 41", busy_n);
    else n_pass++;
    n_total++;
    if (done_n != 1) $display("FAIL binary_done got %0d want 1", done_n);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_gray();
    logic [6:0] exp;
    if0.mode = 1'b1;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    for (int k = 0; k < 42; k++) begin
      if (k < 40) exp = {GRY[k/10], 3'b110, 2'(k/10)};
      else if (k == 40) exp = DONE_V;
      else exp = 7'd0;
      if (obs0 !== exp) $display("FAIL gray k=%0d got %b want %b", k, obs0, exp);
      else n_pass++;
      n_total++;
      if (k == 15 || k == 25) if0.mode = ~if0.mode;
      @(negedge clk);
    end
    if0.mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    if1.mode = 1'b0;
    if1.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 29; k++) begin
      if (k < 12) exp = {BIN[k%4], 3'b110, 2'(k%4)};
      else if (k == 12) exp = DONE_V;
      else if (k == 13) exp = 7'd0;
      else if (k < 26) exp = {BIN[(k-14)%4], 3'b110, 2'((k-14)%4)};
      else if (k == 26) exp = DONE_V;
      else exp = 7'd0;
      if (obs1 !== exp) $display("FAIL b2b k=%0d got %b want %b", k, obs1, exp);
      else n_pass++;
      n_total++;
      if (k >= 25) if1.start = 1'b0;
      else if (k >= 14) if1.start = k[0];
      @(negedge clk);
    end
  endtask

  task automatic test_hold_zero();
    logic [6:0] exp;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp = {BIN[k], 3'b110, 2'(k)};
      else if (k == 4) exp = DONE_V;
      else exp = 7'd0;
      if (obs2 !== exp) $display("FAIL hold0 k=%0d got %b want %b", k, obs2, exp);
      else n_pass++;
      n_total++;
      @(negedge clk);
    end
  endtask

`ifdef GATE_CHECK_EN
  task automatic test_gate_check();
    if0.mode = 1'b0;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (41) @(negedge clk);
    if ({if0.err_flag, if0.err_count} !== 9'd0)
      $display("FAIL gate_clean got %b want 0", {if0.err_flag, if0.err_count});
    else n_pass++;
    n_total++;
    force_and = 1'b1;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (41) @(negedge clk);
    if ({if0.err_flag, if0.err_count} !== {1'b1, 8'd1})
      $display("FAIL gate_forced got %b want 100000001", {if0.err_flag, if0.err_count});
    else n_pass++;
    n_total++;
    repeat (5) @(negedge clk);
    if ({if0.err_flag, if0.err_count} !== {1'b1, 8'd1})
      $display("FAIL gate_hold got %b want 100000001", {if0.err_flag, if0.err_count});
    else n_pass++;
    n_total++;
    force_and = 1'b0;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if ({if0.err_flag, if0.err_count} !== 9'd0)
      $display("FAIL gate_clear got %b want 0", {if0.err_flag, if0.err_count});
    else n_pass++;
    n_total++;
    repeat (42) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_binary();
    test_gray();
    test_back_to_back();
    test_hold_zero();
`ifdef GATE_CHECK_EN
    test_gate_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
